// File: rtl/pizza_paketleyici_pkg.sv
// rtl/pizza_paketleyici_pkg.sv - shared widths, record layout and FSM encoding for the pizza packer
package pizza_paket;

    localparam int SAYI_GENISLIK  = 7;
    localparam int PAKET_GENISLIK = 8;

    localparam int KALINLIK_MSB = 7;
    localparam int KALINLIK_LSB = 6;
    localparam int MALZEME_BIT  = 5;
    localparam int KABARIK_BIT  = 4;
    localparam int MIKTAR_MSB   = 3;
    localparam int MIKTAR_LSB   = 0;

    typedef enum logic {
        SENKRON = 1'b0,
        IZLE    = 1'b1
    } durum_t;

    function automatic logic [PAKET_GENISLIK-1:0] paket_olustur(
        input logic [1:0] kalinlik,
        input logic       secilen_malzeme,
        input logic       kabarik,
        input logic [3:0] malzeme_miktari
    );
        logic [PAKET_GENISLIK-1:0] p;
        p                           = '0;
        p[KALINLIK_MSB:KALINLIK_LSB] = kalinlik;
        p[MALZEME_BIT]               = secilen_malzeme;
        p[KABARIK_BIT]               = kabarik;
        p[MIKTAR_MSB:MIKTAR_LSB]     = malzeme_miktari;
        return p;
    endfunction

endpackage

// File: rtl/pizza_paketleyici_fifo.sv
// rtl/pizza_paketleyici_fifo.sv - first-word-fall-through record FIFO for accepted pizzas
module paket_fifo #(
    parameter int DERINLIK = 4,
    parameter int GENISLIK = 8
) (
    input  logic                i_saat,
    input  logic                i_reset_n,
    input  logic                i_push,
    input  logic [GENISLIK-1:0] i_veri,
    input  logic                i_pop,
    output logic [GENISLIK-1:0] o_veri,
    output logic                o_dolu,
    output logic                o_bos
);

    localparam int AW = $clog2(DERINLIK);

    logic [GENISLIK-1:0] r_mem [DERINLIK];
    logic [AW-1:0]       r_yaz;
    logic [AW-1:0]       r_oku;
    logic [AW:0]         r_adet;
    logic [GENISLIK-1:0] r_son;
    logic                w_yaz;
    logic                w_oku;

    assign o_bos  = (r_adet == '0);
    assign o_dolu = (r_adet == (AW+1)'(DERINLIK));
    assign w_oku  = i_pop & ~o_bos;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign w_yaz  = i_push & (~o_dolu | w_oku);
    // When empty the last record handed out stays on the output.
    assign o_veri = o_bos ? r_son : r_mem[r_oku];

    always_ff @(posedge i_saat) begin
        if (w_yaz) begin
            r_mem[r_yaz] <= i_veri;
        end
    end

    always_ff @(posedge i_saat or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_yaz  <= '0;
            r_oku  <= '0;
            r_adet <= '0;
            r_son  <= '0;
        end else begin
            if (w_yaz) begin
                r_yaz <= r_yaz + AW'(1);
            end
            if (w_oku) begin
                r_oku <= r_oku + AW'(1);
                r_son <= r_mem[r_oku];
            end
            case ({w_yaz, w_oku})
                2'b10:   r_adet <= r_adet + (AW+1)'(1);
                2'b01:   r_adet <= r_adet - (AW+1)'(1);
                default: r_adet <= r_adet;
            endcase
        end
    end

endmodule

// File: rtl/pizza_paketleyici.sv
// rtl/pizza_paketleyici.sv - watches the pizza machine counter, quality-checks each pizza, queues accepted ones
module pizza_paketleyici
    import pizza_paket::*;
#(
    parameter int FIFO_DERINLIK  = 4,
    parameter int SAYAC_GENISLIK = 8
) (
    input  logic                      saat,
    input  logic                      reset,
    input  logic [1:0]                kalinlik,
    input  logic                      secilen_malzeme,
    input  logic [3:0]                malzeme_miktari,
    input  logic                      kabarik,
    input  logic                      tuzlu,
    input  logic [SAYI_GENISLIK-1:0]  pizza_sayisi,
    output logic                      paket_gecerli,
    input  logic                      paket_hazir,
    output logic [PAKET_GENISLIK-1:0] paket_veri,
    output logic [SAYAC_GENISLIK-1:0] kabul_sayisi,
    output logic [SAYAC_GENISLIK-1:0] red_sayisi,
    output logic                      tasma,
    output logic                      sayac_hata
);

    localparam logic [SAYI_GENISLIK-1:0] SAYI_BIR = SAYI_GENISLIK'(1);

    durum_t                      r_durum;
    logic [SAYI_GENISLIK-1:0]    r_onceki;
    logic [SAYAC_GENISLIK-1:0]   r_kabul;
    logic [SAYAC_GENISLIK-1:0]   r_red;
    logic                        r_tasma;
    logic                        r_hata;

    logic [SAYI_GENISLIK-1:0]    w_fark;
    logic                        w_olay;
    logic                        w_ust_reset;
    logic                        w_hata;
    logic                        w_red;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_dolu;
    logic                        w_bos;
    logic [PAKET_GENISLIK-1:0]   w_kayit;

    assign w_fark      = pizza_sayisi - r_onceki;
    assign w_olay      = (r_durum == IZLE) && (w_fark == SAYI_BIR);
    // Counter dropping to zero from elsewhere means the pizza machine itself was reset.
    assign w_ust_reset = (pizza_sayisi == '0) && (r_onceki != '0);
    assign w_hata      = (r_durum == IZLE) && (w_fark != '0) && (w_fark != SAYI_BIR) && !w_ust_reset;
    assign w_red       = tuzlu || (malzeme_miktari == '0);
    assign w_push      = w_olay && !w_red;
    assign w_pop       = paket_gecerli & paket_hazir;
    assign w_kayit     = paket_olustur(kalinlik, secilen_malzeme, kabarik, malzeme_miktari);

    paket_fifo #(
        .DERINLIK (FIFO_DERINLIK),
        .GENISLIK (PAKET_GENISLIK)
    ) u_fifo (
        .i_saat    (saat),
        .i_reset_n (reset),
        .i_push    (w_push),
        .i_veri    (w_kayit),
        .i_pop     (w_pop),
        .o_veri    (paket_veri),
        .o_dolu    (w_dolu),
        .o_bos     (w_bos)
    );

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            r_durum  <= SENKRON;
            r_onceki <= '0;
            r_kabul  <= '0;
            r_red    <= '0;
            r_tasma  <= 1'b0;
            r_hata   <= 1'b0;
        end else begin
            r_durum  <= IZLE;
            r_onceki <= pizza_sayisi;
            if (w_olay) begin
                if (w_red) begin
                    if (r_red != '1) r_red <= r_red + 1'b1;
                end else begin
                    if (r_kabul != '1) r_kabul <= r_kabul + 1'b1;
                end
            end
            if (w_hata) begin
                r_hata <= 1'b1;
            end
            if (w_push && w_dolu && !w_pop) begin
                r_tasma <= 1'b1;
            end
        end
    end

    assign paket_gecerli = ~w_bos;
    assign kabul_sayisi  = r_kabul;
    assign red_sayisi    = r_red;
    assign tasma         = r_tasma;
    assign sayac_hata    = r_hata;

endmodule

// File: tb/tb_pizza_paketleyici.sv
// tb/tb_pizza_paketleyici.sv - directed and randomized checks of pizza_paketleyici against a queue model
module tb_pizza_paketleyici;

    localparam int D = 4;
    localparam int W = 8;

    logic       saat = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] kalinlik = '0;
    logic       secilen_malzeme = 1'b0;
    logic [3:0] malzeme_miktari = '0;
    logic       kabarik = 1'b0;
    logic       tuzlu = 1'b0;
    logic [6:0] pizza_sayisi = '0;
    logic       paket_gecerli;
    logic       paket_hazir = 1'b0;
    logic [7:0] paket_veri;
    logic [W-1:0] kabul_sayisi;
    logic [W-1:0] red_sayisi;
    logic       tasma;
    logic       sayac_hata;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_son;
    int         m_kabul, m_red, m_onceki;
    bit         m_tasma, m_hata, m_senkron;
    logic [7:0] beklenen_kayit[6];

    pizza_paketleyici #(.FIFO_DERINLIK(D), .SAYAC_GENISLIK(W)) dut (
        .saat            (saat),
        .reset           (reset),
        .kalinlik        (kalinlik),
        .secilen_malzeme (secilen_malzeme),
        .malzeme_miktari (malzeme_miktari),
        .kabarik         (kabarik),
        .tuzlu           (tuzlu),
        .pizza_sayisi    (pizza_sayisi),
        .paket_gecerli   (paket_gecerli),
        .paket_hazir     (paket_hazir),
        .paket_veri      (paket_veri),
        .kabul_sayisi    (kabul_sayisi),
        .red_sayisi      (red_sayisi),
        .tasma           (tasma),
        .sayac_hata      (sayac_hata)
    );

    always #5 saat = ~saat;

    task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        checks++;
        assert (gozlenen === beklenen)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, gozlenen, beklenen);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_son     = 8'h00;
        m_kabul   = 0;
        m_red     = 0;
        m_onceki  = 0;
        m_tasma   = 0;
        m_hata    = 0;
        m_senkron = 1;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_kenar();
        int  fark;
        bit  pop;
        int  sayi;
        sayi = int'(pizza_sayisi);
        pop  = (m_q.size() > 0) && paket_hazir;
        if (pop) m_son = m_q.pop_front();
        if (m_senkron) begin
            m_senkron = 0;
        end else begin
            fark = (sayi - m_onceki + 128) % 128;
            if (fark == 1) begin
                if (tuzlu || malzeme_miktari == 0) begin
                    if (m_red < (1 << W) - 1) m_red++;
                end else begin
                    if (m_kabul < (1 << W) - 1) m_kabul++;
                    if (m_q.size() < D) m_q.push_back({kalinlik, secilen_malzeme, kabarik, malzeme_miktari});
                    else m_tasma = 1;
                end
            end else if (fark != 0 && !(sayi == 0 && m_onceki != 0)) begin
                m_hata = 1;
            end
        end
        m_onceki = sayi;
    endtask

    task automatic tumunu_kontrol(input string tag);
        kontrol({tag, ".gecerli"}, 32'(paket_gecerli), 32'(m_q.size() > 0));
        kontrol({tag, ".veri"}, 32'(paket_veri), 32'((m_q.size() > 0) ? m_q[0] : m_son));
        kontrol({tag, ".kabul"}, 32'(kabul_sayisi), 32'(m_kabul));
        kontrol({tag, ".red"}, 32'(red_sayisi), 32'(m_red));
        kontrol({tag, ".tasma"}, 32'(tasma), 32'(m_tasma));
        kontrol({tag, ".hata"}, 32'(sayac_hata), 32'(m_hata));
    endtask

    task automatic adim(input string tag);
        model_kenar();
        @(posedge saat);
        #1;
        tumunu_kontrol(tag);
    endtask

    // Asserts reset between edges, checks the outputs clear at once, releases after one edge.
    task automatic reset_uygula(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        kontrol({tag, ".rst_gecerli"}, 32'(paket_gecerli), 32'(0));
        kontrol({tag, ".rst_kabul"}, 32'(kabul_sayisi), 32'(0));
        kontrol({tag, ".rst_red"}, 32'(red_sayisi), 32'(0));
        kontrol({tag, ".rst_tasma"}, 32'(tasma), 32'(0));
        kontrol({tag, ".rst_hata"}, 32'(sayac_hata), 32'(0));
        kontrol({tag, ".rst_veri"}, 32'(paket_veri), 32'(0));
        @(posedge saat);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;

        // 1: reset state, steady count
        reset_uygula("t1");
        pizza_sayisi = 7'd5;
        repeat (3) adim("t1");
        kontrol("t1.gecerli", 32'(paket_gecerli), 32'(0));
        kontrol("t1.kabul", 32'(kabul_sayisi), 32'(0));

        // 2: single accepted pizza, latency and pop
        kalinlik = 2'd2; secilen_malzeme = 1'b1; malzeme_miktari = 4'd7;
        kabarik = 1'b1; tuzlu = 1'b0; paket_hazir = 1'b1;
        pizza_sayisi = 7'd6;
        adim("t2");
        kontrol("t2.gecerli", 32'(paket_gecerli), 32'(1));
        kontrol("t2.veri", 32'(paket_veri), 32'h0000_00B7);
        kontrol("t2.kabul", 32'(kabul_sayisi), 32'(1));
        adim("t2pop");
        kontrol("t2.popped", 32'(paket_gecerli), 32'(0));

        // 3: rejections
        tuzlu = 1'b1; pizza_sayisi = 7'd7;
        adim("t3a");
        kontrol("t3.red1", 32'(red_sayisi), 32'(1));
        tuzlu = 1'b0; malzeme_miktari = 4'd0; pizza_sayisi = 7'd8;
        adim("t3b");
        kontrol("t3.red2", 32'(red_sayisi), 32'(2));
        kontrol("t3.nopush", 32'(paket_gecerli), 32'(0));

        // 4: overflow with packaging stalled, then drain in order
        paket_hazir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            kalinlik = 2'(i); secilen_malzeme = i[0]; kabarik = ~i[0];
            malzeme_miktari = 4'(i + 1);
            beklenen_kayit[i] = {kalinlik, secilen_malzeme, kabarik, malzeme_miktari};
            pizza_sayisi = 7'(9 + i);
            adim("t4fill");
        end
        kontrol("t4.tasma", 32'(tasma), 32'(1));
        kontrol("t4.kabul", 32'(kabul_sayisi), 32'(7));
        paket_hazir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kontrol("t4.sira", 32'(paket_veri), 32'(beklenen_kayit[i]));
            adim("t4drain");
        end
        kontrol("t4.bos", 32'(paket_gecerli), 32'(0));

        // 5a: upstream reset 40->0 resyncs quietly
        tuzlu = 1'b0; malzeme_miktari = 4'd5;
        pizza_sayisi = 7'd40;
        reset_uygula("t5a");
        adim("t5a_senkron");
        pizza_sayisi = 7'd0;
        adim("t5a");
        kontrol("t5a.hata", 32'(sayac_hata), 32'(0));
        kontrol("t5a.kabul", 32'(kabul_sayisi), 32'(0));
        pizza_sayisi = 7'd1;
        adim("t5a_next");
        kontrol("t5a.kabul1", 32'(kabul_sayisi), 32'(1));

        // 5b: wrap 127->0 is one pizza; 10->13 is a counting error
        pizza_sayisi = 7'd127;
        reset_uygula("t5b");
        adim("t5b_senkron");
        pizza_sayisi = 7'd0;
        adim("t5b_wrap");
        kontrol("t5b.wrap", 32'(kabul_sayisi), 32'(1));
        for (int v = 1; v <= 10; v++) begin
            pizza_sayisi = 7'(v);
            adim("t5b_inc");
        end
        pizza_sayisi = 7'd13;
        adim("t5b_jump");
        kontrol("t5b.hata", 32'(sayac_hata), 32'(1));
        kontrol("t5b.kabul", 32'(kabul_sayisi), 32'(11));

        // 6: reset with records queued
        paket_hazir = 1'b0;
        for (int v = 14; v <= 16; v++) begin
            pizza_sayisi = 7'(v);
            adim("t6fill");
        end
        kontrol("t6.dolu", 32'(paket_gecerli), 32'(1));
        reset_uygula("t6");
        pizza_sayisi = 7'd50;
        adim("t6_senkron");
        kontrol("t6.senkron_kabul", 32'(kabul_sayisi), 32'(0));
        kontrol("t6.senkron_gecerli", 32'(paket_gecerli), 32'(0));
        pizza_sayisi = 7'd51;
        adim("t6_next");
        kontrol("t6.kabul", 32'(kabul_sayisi), 32'(1));

        // saturation of the accepted counter
        paket_hazir = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pizza_sayisi = pizza_sayisi + 7'd1;
            adim("sat");
        end
        kontrol("sat.kabul", 32'(kabul_sayisi), 32'(255));

        // randomized traffic
        reset_uygula("rnd");
        for (int i = 0; i < 400; i++) begin
            int sec;
            sec = int'($urandom_range(0, 9));
            if (sec < 3)       pizza_sayisi = pizza_sayisi;
            else if (sec < 8)  pizza_sayisi = pizza_sayisi + 7'd1;
            else if (sec == 8) pizza_sayisi = 7'($urandom_range(0, 127));
            else               pizza_sayisi = 7'd0;
            kalinlik        = 2'($urandom_range(0, 3));
            secilen_malzeme = 1'($urandom_range(0, 1));
            kabarik         = 1'($urandom_range(0, 1));
            malzeme_miktari = 4'($urandom_range(0, 15));
            tuzlu           = ($urandom_range(0, 4) == 0);
            paket_hazir     = ($urandom_range(0, 2) != 0);
            adim("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
